// File: rtl/pdp8_kl8.sv
// PDP-8 KL8 console teletype: keyboard receiver (KBD_DEV) and printer transmitter (TTY_DEV)
// behind the IOT bus, with byte-stream handshakes toward the host.
module pdp8_kl8 #(
    parameter logic [5:0]  KBD_DEV     = 6'o03,
    parameter logic [5:0]  TTY_DEV     = 6'o04,
    parameter int unsigned PRINT_DELAY = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iot,
    input  logic [11:0] mb,
    input  logic [5:0]  io_select,
    input  logic [11:0] io_data_in,
    output logic [11:0] io_data_out,
    output logic        io_data_avail,
    output logic        io_skip,
    output logic        io_interrupt,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned CW = (PRINT_DELAY > 1) ? $clog2(PRINT_DELAY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(PRINT_DELAY - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait} tty_state_e;

    tty_state_e    state;
    logic [CW-1:0] counter;
    logic          kbd_flag;
    logic          tty_flag;
    logic [7:0]    kbuf;
    logic          iot_q;

    logic       iot_rise;
    logic       kbd_sel;
    logic       tty_sel;
    logic [2:0] pulse;
    logic       kbd_clear;
    logic       tty_cmd;
    logic       tty_set;
    logic       tty_clr;
    logic       print_start;
    logic       wait_done;
    logic       unused_mb;

    assign pulse     = mb[2:0];
    assign unused_mb = ^mb[11:3];
    assign iot_rise  = iot & ~iot_q;
    assign kbd_sel   = iot && (io_select == KBD_DEV);
    assign tty_sel   = iot && (io_select == TTY_DEV);

    assign kbd_clear   = kbd_sel && iot_rise &&
                         (pulse == 3'd0 || pulse == 3'd2 || pulse == 3'd6);
    assign tty_cmd     = tty_sel && iot_rise;
    assign tty_set     = tty_cmd && (pulse == 3'd0);
    assign tty_clr     = tty_cmd && (pulse == 3'd2 || pulse == 3'd6);
    assign print_start = tty_cmd && (pulse == 3'd4 || pulse == 3'd6);
    assign wait_done   = (state == StWait) && (counter == '0);

    assign rx_ready     = ~kbd_flag;
    assign io_interrupt = kbd_flag | tty_flag;

    always_comb begin
        io_data_avail = 1'b0;
        io_skip       = 1'b0;
        io_data_out   = '0;
        if (kbd_sel) begin
            case (pulse)
                3'd1: io_skip = kbd_flag;
                3'd2: io_data_avail = 1'b1;
                3'd4: begin
                    io_data_avail = 1'b1;
                    io_data_out   = io_data_in | {4'b0, kbuf};
                end
                3'd6: begin
                    io_data_avail = 1'b1;
                    io_data_out   = {4'b0, kbuf};
                end
                default: ;
            endcase
        end else if (tty_sel) begin
            if (pulse == 3'd1) io_skip = tty_flag;
        end
    end

    // Keyboard side; a CPU clear beats a simultaneous host byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            iot_q    <= 1'b0;
            kbd_flag <= 1'b0;
            kbuf     <= '0;
        end else begin
            iot_q <= iot;
            if (kbd_clear) begin
                kbd_flag <= 1'b0;
            end else if (rx_valid && !kbd_flag) begin
                kbd_flag <= 1'b1;
                kbuf     <= rx_data;
            end
        end
    end

    // Printer FSM; an explicit TFL/TCF/TLS overrides the end-of-print flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            counter  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tty_flag <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (print_start) begin
                        tx_data  <= io_data_in[7:0];
                        tx_valid <= 1'b1;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        counter  <= CNT_INIT;
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (counter == '0) state <= StIdle;
                    else               counter <= counter - CW'(1);
                end
                default: state <= StIdle;
            endcase

            if (tty_set)        tty_flag <= 1'b1;
            else if (tty_clr)   tty_flag <= 1'b0;
            else if (wait_done) tty_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pdp8_kl8.sv
// Directed-vector bench for the KL8 console teletype.
module tb_pdp8_kl8;

    localparam int unsigned D = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        iot;
    logic [11:0] mb;
    logic [5:0]  io_select;
    logic [11:0] io_data_in;
    logic [11:0] io_data_out;
    logic        io_data_avail;
    logic        io_skip;
    logic        io_interrupt;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    pdp8_kl8 #(
        .KBD_DEV    (6'o03),
        .TTY_DEV    (6'o04),
        .PRINT_DELAY(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iot          (iot),
        .mb           (mb),
        .io_select    (io_select),
        .io_data_in   (io_data_in),
        .io_data_out  (io_data_out),
        .io_data_avail(io_data_avail),
        .io_skip      (io_skip),
        .io_interrupt (io_interrupt),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [11:0] m, input logic [11:0] ac);
        @(posedge clk); #1;
        iot = 1'b1; mb = m; io_select = m[8:3]; io_data_in = ac;
        #1;
    endtask

    task automatic iot_low();
        iot = 1'b0; mb = '0; io_select = '0; io_data_in = '0;
        #1;
    endtask

    task automatic drop();
        @(posedge clk); #1;
        iot_low();
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_cmp++; if (io_interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", io_interrupt); end
        n_cmp++; if ({io_data_avail, io_skip, io_data_out} !== 14'd0) begin
            n_err++; $display("FAIL reset_comb got %b%b%o want all 0", io_data_avail, io_skip, io_data_out);
        end
        // Another device's IOT must be ignored.
        iot = 1'b1; mb = 12'o6052; io_select = 6'o05; io_data_in = 12'o7777;
        #1;
        n_cmp++; if ({io_data_avail, io_skip, io_data_out} !== 14'd0) begin
            n_err++; $display("FAIL foreign_dev got %b%b%o want all 0", io_data_avail, io_skip, io_data_out);
        end
        drop();
    endtask

    task automatic test_kbd();
        send_rx(8'h41);
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL kbd_rx_ready got %b want 0", rx_ready); end
        n_cmp++; if (io_interrupt !== 1'b1) begin n_err++; $display("FAIL kbd_irq got %b want 1", io_interrupt); end
        issue(12'o6031, 12'o0000);
        n_cmp++; if (io_skip !== 1'b1) begin n_err++; $display("FAIL ksf_set got %b want 1", io_skip); end
        drop();
        issue(12'o6036, 12'o0000);
        n_cmp++; if (io_data_avail !== 1'b1) begin n_err++; $display("FAIL krb_avail got %b want 1", io_data_avail); end
        n_cmp++; if (io_data_out !== 12'o0101) begin n_err++; $display("FAIL krb_data got %o want 0101", io_data_out); end
        drop();
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL krb_clear got %b want 1", rx_ready); end
        n_cmp++; if (io_interrupt !== 1'b0) begin n_err++; $display("FAIL krb_irq got %b want 0", io_interrupt); end
        issue(12'o6031, 12'o0000);
        n_cmp++; if (io_skip !== 1'b0) begin n_err++; $display("FAIL ksf_clr got %b want 0", io_skip); end
        drop();
    endtask

    task automatic test_krs_kcc();
        send_rx(8'h41);
        issue(12'o6034, 12'o7400);
        n_cmp++; if (io_data_avail !== 1'b1) begin n_err++; $display("FAIL krs_avail got %b want 1", io_data_avail); end
        n_cmp++; if (io_data_out !== 12'o7501) begin n_err++; $display("FAIL krs_data got %o want 7501", io_data_out); end
        drop();
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL krs_flag got rx_ready %b want 0", rx_ready); end
        issue(12'o6032, 12'o1234);
        n_cmp++; if ({io_data_avail, io_data_out} !== {1'b1, 12'o0000}) begin
            n_err++; $display("FAIL kcc_data got %b/%o want 1/0000", io_data_avail, io_data_out);
        end
        drop();
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL kcc_clear got %b want 1", rx_ready); end
    endtask

    task automatic test_held_iot();
        send_rx(8'h41);
        issue(12'o6036, 12'o0000);
        @(posedge clk); #1;
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL hold_first_clear got %b want 1", rx_ready); end
        rx_valid = 1'b1; rx_data = 8'h55;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL hold_no_reclear got %b want 0", rx_ready); end
        n_cmp++; if (io_data_out !== 12'o0125) begin n_err++; $display("FAIL hold_data got %o want 0125", io_data_out); end
        iot_low();
        issue(12'o6036, 12'o0000);
        n_cmp++; if (io_data_out !== 12'o0125) begin n_err++; $display("FAIL hold_second_byte got %o want 0125", io_data_out); end
        drop();
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL hold_final_clear got %b want 1", rx_ready); end
    endtask

    task automatic test_print();
        int n;
        tx_ready = 1'b0;
        issue(12'o6046, 12'o0215);
        @(posedge clk); #1;
        iot_low();
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL tls_valid got %b want 1", tx_valid); end
        n_cmp++; if (tx_data !== 8'h8D) begin n_err++; $display("FAIL tls_data got %h want 8d", tx_data); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h8D}) begin
            n_err++; $display("FAIL send_hold got %b/%h want 1/8d", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL send_done got %b want 0", tx_valid); end
        n_cmp++; if (io_interrupt !== 1'b0) begin n_err++; $display("FAIL early_flag got %b want 0", io_interrupt); end
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (io_interrupt) begin n = i; break; end
        end
        n_cmp++; if (n !== D) begin n_err++; $display("FAIL print_delay got %0d want %0d", n, D); end
        issue(12'o6041, 12'o0000);
        n_cmp++; if (io_skip !== 1'b1) begin n_err++; $display("FAIL tsf_set got %b want 1", io_skip); end
        drop();
        issue(12'o6042, 12'o0000);
        drop();
        n_cmp++; if (io_interrupt !== 1'b0) begin n_err++; $display("FAIL tcf got %b want 0", io_interrupt); end
        issue(12'o6041, 12'o0000);
        n_cmp++; if (io_skip !== 1'b0) begin n_err++; $display("FAIL tsf_clr got %b want 0", io_skip); end
        drop();
        issue(12'o6040, 12'o0000);
        drop();
        n_cmp++; if (io_interrupt !== 1'b1) begin n_err++; $display("FAIL tfl got %b want 1", io_interrupt); end
        issue(12'o6042, 12'o0000);
        drop();
    endtask

    task automatic test_busy();
        int n;
        tx_ready = 1'b1;
        issue(12'o6046, 12'o0101);
        @(posedge clk); #1;
        iot_low();
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
            n_err++; $display("FAIL busy_start got %b/%h want 1/41", tx_valid, tx_data);
        end
        @(posedge clk); #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL busy_accept got %b want 0", tx_valid); end
        issue(12'o6044, 12'o0377);
        @(posedge clk); #1;
        iot_low();
        n_cmp++; if ({tx_valid, tx_data} !== {1'b0, 8'h41}) begin
            n_err++; $display("FAIL busy_ignore got %b/%h want 0/41", tx_valid, tx_data);
        end
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (io_interrupt) begin n = i; break; end
        end
        n_cmp++; if (n !== D - 2) begin n_err++; $display("FAIL busy_delay got %0d want %0d", n, D - 2); end
        issue(12'o6042, 12'o0000);
        drop();
        repeat (3 * D) @(posedge clk);
        #1;
        n_cmp++; if ({io_interrupt, tx_valid, tx_data} !== {1'b0, 1'b0, 8'h41}) begin
            n_err++; $display("FAIL busy_single got %b/%b/%h want 0/0/41", io_interrupt, tx_valid, tx_data);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        issue(12'o6046, 12'o0007);
        @(posedge clk); #1;
        iot_low();
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL mid_send got %b want 1", tx_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if ({tx_valid, tx_data, io_interrupt} !== 10'd0) begin
            n_err++; $display("FAIL mid_reset got %b/%h/%b want 0/00/0", tx_valid, tx_data, io_interrupt);
        end
        tx_ready = 1'b1;
        repeat (3 * D) @(posedge clk);
        #1;
        n_cmp++; if ({tx_valid, io_interrupt} !== 2'b00) begin
            n_err++; $display("FAIL mid_aborted got %b/%b want 0/0", tx_valid, io_interrupt);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; iot = 1'b0; mb = '0; io_select = '0; io_data_in = '0;
        rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        test_reset();
        test_kbd();
        test_krs_kcc();
        test_held_iot();
        test_print();
        test_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pdp8_kl8.md
PDP8_KL8 -- requirements
Module: pdp8_kl8

Interface
REQ-001 SHALL have parameter KBD_DEV, default 6'o03, keyboard device code.
REQ-002 SHALL have parameter TTY_DEV, default 6'o04, printer device code.
REQ-003 SHALL have parameter PRINT_DELAY, default 16, cycles from printer byte accept to flag set (min 1).
REQ-004 Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- iot  in  1  CPU IOT cycle active.
- mb  in  12  current instruction; mb[2:0] = pulse bits.
- io_select  in  6  device code (mb[8:3]).
- io_data_in  in  12  CPU AC.
- io_data_out  out  12  value CPU loads into AC when io_data_avail=1.
- io_data_avail  out  1  io_data_out valid this cycle.
- io_skip  out  1  skip next instruction.
- io_interrupt  out  1  interrupt request.
- rx_valid  in  1  host keyboard byte offered.
- rx_data  in  8  keyboard byte.
- rx_ready  out  1  keyboard can accept.
- tx_valid  out  1  printer byte offered to host.
- tx_data  out  8  printer byte.
- tx_ready  in  1  host accepts printer byte.

Function
REQ-005 Device SHALL decode only when iot=1 and io_select equals KBD_DEV or TTY_DEV; otherwise io_data_avail, io_skip, io_data_out SHALL be 0.
REQ-006 io_skip, io_data_avail, io_data_out SHALL be combinational from iot, mb, io_select, io_data_in and internal state.
REQ-007 Flag/register side effects SHALL occur once per IOT, on the first cycle of an iot assertion (rising-edge detect on iot); held iot SHALL NOT repeat them.
REQ-008 Keyboard (KBD_DEV), pulse bits mb[2:0]: 0=KCF clear kbd_flag; 1=KSF skip if kbd_flag; 2=KCC clear kbd_flag, AC<-0; 4=KRS AC<-AC|{4'b0,kbuf}; 6=KRB AC<-{4'b0,kbuf}, clear kbd_flag; other codes no effect.
REQ-009 "AC<-X" SHALL mean io_data_avail=1 and io_data_out=X for the whole iot assertion.
REQ-010 rx_ready SHALL equal !kbd_flag; on rx_valid&rx_ready, kbuf<=rx_data and kbd_flag<=1 next edge.
REQ-011 If a KCF/KCC/KRB clear and an rx accept coincide (impossible while flag set), the clear takes priority.
REQ-012 Printer (TTY_DEV), pulse bits: 0=TFL set tty_flag; 1=TSF skip if tty_flag; 2=TCF clear tty_flag; 4=TPC start print of io_data_in[7:0]; 6=TLS clear tty_flag and start print; other codes no effect.
REQ-013 Printer FSM states IDLE, SEND, WAIT. IDLE: print start -> latch tx_data, go SEND. SEND: tx_valid=1; on tx_ready go WAIT, counter<=PRINT_DELAY-1. WAIT: decrement; at 0 set tty_flag, go IDLE.
REQ-014 tx_data SHALL be stable while tx_valid=1; tx_valid SHALL be 1 only in SEND.
REQ-015 Print start while not IDLE SHALL be ignored (byte dropped, state unchanged); TLS flag clear still applies.
REQ-016 TFL/TCF and the WAIT flag-set in the same cycle: explicit IOT wins.
REQ-017 io_interrupt SHALL equal kbd_flag | tty_flag, registered-flag based, no extra latency.

Reset
REQ-018 On reset: kbd_flag=0, tty_flag=0, kbuf=0, FSM=IDLE, counter=0, tx_valid=0, tx_data=0, io_interrupt=0, iot edge detector cleared; reset mid-print SHALL abort with no flag set.
REQ-019 After reset: rx_ready=1; all combinational outputs 0 while iot=0.

Verification
REQ-020 rx_valid=1, rx_data=8'h41 one cycle -> kbd_flag=1, rx_ready=0, io_interrupt=1; IOT 6031 -> io_skip=1; IOT 6036 -> io_data_avail=1, io_data_out=12'o0101, then kbd_flag=0.
REQ-021 AC=12'o7400, kbuf=8'h41, IOT 6034 -> io_data_out=12'o7501, kbd_flag unchanged.
REQ-022 IOT 6046 with AC=12'o0215 -> tx_valid=1, tx_data=8'h8D; tx_ready low 5 cycles -> tx_valid held; tx_ready=1 -> tx_valid=0, tty_flag=1 exactly PRINT_DELAY cycles later; IOT 6041 -> io_skip=1.
REQ-023 iot held 4 cycles on 6036 -> flag cleared once, second rx byte arriving during hold not lost.
REQ-024 Second IOT 6044 during WAIT -> ignored, tx_data unchanged, single flag set.
REQ-025 reset asserted in SEND -> tx_valid=0 next cycle, tty_flag=0, FSM IDLE.
